div_sequencer: RTL
==================

# div_sequencer

Sequencer between the EX stage and the iterative 32-cycle divider in the integer pipeline. It accepts DIV/DIVU requests from EX, drives the divider's start/annul/operand handshake, and stalls the pipeline while the divide runs. It cancels in-flight divides on pipeline flush and delivers the remainder/quotient as a one-cycle HI/LO write.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `ex_div_valid_i`  in  1  EX holds a DIV/DIVU instruction.
- `ex_op_i`  in  5  op control; only `DIV_CONTROL` / `DIVU_CONTROL` are presented.
- `ex_a_i`, `ex_b_i`  in  32 each  dividend, divisor.
- `flush_i`  in  1  pipeline flush; kills the EX instruction.
- `stall_o`  out  1  combinational; holds IF..EX.
- `hilo_we_o`  out  1  combinational; HI/LO write strobe.
- `hi_o`, `lo_o`  out  32 each  registered remainder and quotient.
- `div_start_o`  out  1  registered; divider start.
- `div_annul_o`  out  1  registered; divider annul.
- `div_op_o`  out  5  registered; op latched at accept.
- `div_a_o`, `div_b_o`  out  32 each  registered; operands latched at accept.
- `div_result_i`  in  64  divider result: {remainder, quotient}.
- `div_ready_i`  in  1  divider result ready.

## Operation
- States: IDLE, BUSY, DONE, ABORT (ABORT runs 2 cycles via a 1-bit counter).
- Reset values: state = IDLE. `div_start_o`, `div_annul_o` = 0. `div_op_o`, `div_a_o`, `div_b_o`, `hi_o`, `lo_o` = 0.
- IDLE:
  - `stall_o` = `ex_div_valid_i & ~flush_i`.
  - On accept (`ex_div_valid_i & ~flush_i`): latch op/a/b, set `div_start_o` = 1, go to BUSY.
  - If `flush_i` is high, nothing is accepted and the block stays in IDLE.
- BUSY:
  - `stall_o` = 1. `div_start_o` is held at 1.
  - If `flush_i` = 1: clear `div_start_o`, set `div_annul_o` = 1 for exactly one cycle, go to ABORT. Flush has priority over a simultaneous `div_ready_i`.
  - Else if `div_ready_i` = 1: `hi_o` ← `div_result_i[63:32]`, `lo_o` ← `div_result_i[31:0]`, clear `div_start_o`, go to DONE.
- DONE (1 cycle):
  - `stall_o` = 0. `hilo_we_o` = `~flush_i`.
  - `ex_div_valid_i` is ignored in this cycle (it is the same instruction leaving EX).
  - Next state is IDLE.
- ABORT (2 cycles):
  - `stall_o` = `ex_div_valid_i`. `div_start_o` = 0.
  - `div_annul_o` is high only in the first ABORT cycle.
  - After 2 cycles go to IDLE. This guarantees the divider has returned to free, including from its divide-by-zero path.
- `hilo_we_o` is 0 in every state other than DONE.
- Divide-by-zero needs no special handling here: the divider returns a 0 result, which is written normally.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The divider is reset by the same `rst` domain.

## Timing
- Edge E0 is the end of the accept cycle c0.
- Normal divide: divider ready visible after E35, DONE entered at E36.
  - `stall_o` is high for cycles c0..c36 (37 cycles).
  - `hilo_we_o` is high in c37.
- Divisor = 0: DONE entered at E4; stall lasts 5 cycles; `hilo_we_o` is high in c5.
- A new request can be accepted in the first IDLE cycle after DONE. The divider is free by then: `div_start_o` went low at the DONE entry edge, and the divider leaves its end state one edge later.
- Flush in BUSY: ABORT for 2 cycles, then IDLE. The earliest next start is 3 cycles after the flush cycle.

## Configuration
- `DIV_RESULT_CACHE_EN` defined:
  - Adds a one-entry cache holding {valid, op, a, b, result}. Valid is cleared on reset.
  - The cache is written on every BUSY→DONE transition. It is not written on abort.
  - In IDLE, an accept whose {op, a, b} matches a valid entry goes straight to DONE: hi/lo are loaded from the cache, `div_start_o` stays 0, and stall lasts 1 cycle.
- `DIV_RESULT_CACHE_EN` undefined: no cache logic; every accept starts the divider.

## Test plan
- DIVU a=100, b=7 → 37 stall cycles, then `hilo_we_o`=1 for one cycle with hi=2, lo=14.
- DIV a=−100 (0xFFFFFF9C), b=7 → hi=0xFFFFFFFE, lo=0xFFFFFFF2. Then immediately DIVU a=0xFFFFFFFF, b=2 → hi=1, lo=0x7FFFFFFF. The second divide starts the cycle after DONE.
- DIVU b=0 → 5 stall cycles, hi=0, lo=0, `hilo_we_o` pulses.
- Flush 10 cycles into BUSY:
  - `div_annul_o` pulses once and `hilo_we_o` never fires.
  - A new DIVU 9/3 presented during ABORT stays stalled, is accepted 3 cycles after the flush, and yields hi=0, lo=3.
- Flush in the DONE cycle → `hilo_we_o`=0 while `hi_o`/`lo_o` still update. Flush coinciding with `div_ready_i` in BUSY → ABORT, no write.
- `DIV_RESULT_CACHE_EN`: repeat DIVU 100/7 → 1 stall cycle, `div_start_o` stays 0, hi=2, lo=14. Changing b to 8 misses the cache → 37 stall cycles, lo=12.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: sits between EX and the 32-cycle iterative divider.
// It accepts DIV/DIVU from EX, drives the divider start/annul/operand
// handshake, stalls IF..EX while a divide runs, cancels in-flight divides
// on flush, and writes remainder/quotient to HI/LO as a one-cycle strobe.
//
// Optional feature: define DIV_RESULT_CACHE_EN to add a one-entry cache of
// the last completed {op, a, b, result}. When a new request matches it,
// the divider is skipped.
//
// Ports
//   clk, rst            clock, async active-low reset
//   ex_div_valid_i      EX holds a DIV/DIVU
//   ex_op_i/a_i/b_i     op control, dividend, divisor
//   flush_i             pipeline flush
//   stall_o             combinational stall of IF..EX
//   hilo_we_o           combinational HI/LO write strobe
//   hi_o, lo_o          registered remainder / quotient
//   div_start_o         registered divider start
//   div_annul_o         registered divider annul
//   div_op_o/a_o/b_o    registered op and operands latched at accept
//   div_result_i        divider result {remainder, quotient}
//   div_ready_i         divider result ready
//
// state | meaning
// IDLE  | waiting for a request from EX
// BUSY  | divider running, pipeline stalled
// DONE  | one cycle, HI/LO written unless flushed
// ABORT | two cycles after a flush so the divider returns to free
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid_i,
  input  logic [4:0]  ex_op_i,
  input  logic [31:0] ex_a_i,
  input  logic [31:0] ex_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic [4:0]  div_op_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        abort_cnt_q, abort_cnt_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        accept;

  assign accept = ex_div_valid_i & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_vld_q;
  logic [4:0]  cache_op_q;
  logic [31:0] cache_a_q;
  logic [31:0] cache_b_q;
  logic [63:0] cache_res_q;
  logic        cache_hit;
  logic        cache_we;

  assign cache_hit = cache_vld_q && (cache_op_q == ex_op_i) &&
                     (cache_a_q == ex_a_i) && (cache_b_q == ex_b_i);
  // Only completed divides are cached; aborted ones never reach DONE.
  assign cache_we  = (state_q == S_BUSY) && !flush_i && div_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= '0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_res_q <= '0;
    end else if (cache_we) begin
      cache_vld_q <= 1'b1;
      cache_op_q  <= op_q;
      cache_a_q   <= a_q;
      cache_b_q   <= b_q;
      cache_res_q <= div_result_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      abort_cnt_q <= 1'b0;
      start_q     <= 1'b0;
      annul_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      abort_cnt_q <= abort_cnt_d;
      start_q     <= start_d;
      annul_q     <= annul_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    abort_cnt_d = abort_cnt_q;
    start_d     = start_q;
    annul_d     = 1'b0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = ex_op_i;
          a_d     = ex_a_i;
          b_d     = ex_b_i;
          start_d = 1'b1;
          state_d = S_BUSY;
`ifdef DIV_RESULT_CACHE_EN
          if (cache_hit) begin
            hi_d    = cache_res_q[63:32];
            lo_d    = cache_res_q[31:0];
            start_d = 1'b0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        // Flush wins over a result arriving in the same cycle.
        if (flush_i) begin
          start_d     = 1'b0;
          annul_d     = 1'b1;
          abort_cnt_d = 1'b0;
          state_d     = S_ABORT;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          start_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        start_d = 1'b0;
        if (abort_cnt_q) state_d = S_IDLE;
        else             abort_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    hilo_we_o = 1'b0;
    case (state_q)
      S_IDLE:  stall_o   = accept;
      S_BUSY:  stall_o   = 1'b1;
      S_DONE:  hilo_we_o = ~flush_i;
      S_ABORT: stall_o   = ex_div_valid_i;
      default: stall_o   = 1'b0;
    endcase
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div_start_o = start_q;
  assign div_annul_o = annul_q;
  assign div_op_o    = op_q;
  assign div_a_o     = a_q;
  assign div_b_o     = b_q;

endmodule
